// File: rtl/dca_lsu_write_aligner_pkg.sv
// Shared LSU definitions: write-aligner FSM states and width helpers, also used by the read-side LSU.
package dca_lsu_write_aligner_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int calc_bw_offset(input int bw_row_buffer);
        return $clog2(bw_row_buffer);
    endfunction

    function automatic int calc_num_beat(input int bw_row_buffer, input int bw_axi_data);
        return bw_row_buffer / bw_axi_data;
    endfunction

    function automatic int calc_bw_strb(input int bw_data);
        return bw_data / 8;
    endfunction

endpackage

// File: rtl/dca_lsu_write_aligner_if.sv
// Store-request and AXI W channel bundle between the LSU front end and the write aligner.
interface dca_lsu_write_aligner_if
    import dca_lsu_write_aligner_pkg::*;
#(
    parameter int BW_AXI_DATA   = 32,
    parameter int BW_ROW_BUFFER = 128,
    parameter int BW_NUM_BYTE   = 5
);
    localparam int BW_OFFSET = calc_bw_offset(BW_ROW_BUFFER);
    localparam int BW_STRB   = calc_bw_strb(BW_AXI_DATA);

    logic                     req_valid;
    logic                     req_ready;
    logic [BW_ROW_BUFFER-1:0] req_data;
    logic [BW_OFFSET-1:0]     req_offset;
    logic [BW_NUM_BYTE-1:0]   req_num_byte;
    logic [7:0]               req_alen;
    logic                     wvalid;
    logic                     wready;
    logic [BW_AXI_DATA-1:0]   wdata;
    logic [BW_STRB-1:0]       wstrb;
    logic                     wlast;

    modport master (
        output req_valid, req_data, req_offset, req_num_byte, req_alen, wready,
        input  req_ready, wvalid, wdata, wstrb, wlast
    );

    modport slave (
        input  req_valid, req_data, req_offset, req_num_byte, req_alen, wready,
        output req_ready, wvalid, wdata, wstrb, wlast
    );

endinterface

// File: rtl/ERVP_BARREL_SHIFTER.sv
// Generic combinational barrel shifter: left/right, logical/arithmetic/circular, optional signed amount.
module ERVP_BARREL_SHIFTER #(
    parameter int BW_DATA          = 32,
    parameter int BW_SHIFT_AMOUNT  = 5,
    parameter int SIGNED_AMOUNT    = 0,
    parameter int PLUS_TO_LEFT     = 1,
    parameter int ARITHMETIC_SHIFT = 0,
    parameter int CIRCULAR_SHIFT   = 0,
    parameter int MSB_FILL_VALUE   = 0
) (
    input  logic [BW_DATA-1:0]         data_input,
    input  logic [BW_SHIFT_AMOUNT-1:0] shift_amount,
    output logic [BW_DATA-1:0]         data_output
);
    logic                       neg_s;
    logic                       to_left_s;
    logic                       fill_s;
    logic [BW_SHIFT_AMOUNT-1:0] mag_s;
    logic [2*BW_DATA-1:0]       ext_s;

    // A negative signed amount flips the direction; shifting a double-width vector covers rotate and fill
    always_comb begin
        ext_s       = '0;
        data_output = '0;
        neg_s       = (SIGNED_AMOUNT != 0) && shift_amount[BW_SHIFT_AMOUNT-1];
        mag_s       = neg_s ? (~shift_amount + BW_SHIFT_AMOUNT'(1)) : shift_amount;
        to_left_s   = (PLUS_TO_LEFT != 0) ^ neg_s;
        fill_s      = (ARITHMETIC_SHIFT != 0) ? data_input[BW_DATA-1] : (MSB_FILL_VALUE != 0);
        if (to_left_s) begin
            ext_s       = (CIRCULAR_SHIFT != 0) ? {data_input, data_input} : {data_input, {BW_DATA{1'b0}}};
            ext_s       = ext_s << mag_s;
            data_output = ext_s[2*BW_DATA-1:BW_DATA];
        end else begin
            ext_s       = (CIRCULAR_SHIFT != 0) ? {data_input, data_input} : {{BW_DATA{fill_s}}, data_input};
            ext_s       = ext_s >> mag_s;
            data_output = ext_s[BW_DATA-1:0];
        end
    end

endmodule

// File: rtl/dca_lsu_write_aligner.sv
// Aligns an LSB-aligned store row to its byte offset and streams it as an AXI W burst.
// Define DCA_LSU_WRITE_SUBBYTE_EN to honour sub-byte offsets (otherwise offsets round down to a byte).
module dca_lsu_write_aligner
    import dca_lsu_write_aligner_pkg::*;
#(
    parameter int BW_AXI_DATA   = 32,
    parameter int BW_ROW_BUFFER = 128,
    parameter int BW_NUM_BYTE   = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    dca_lsu_write_aligner_if.slave    bus,
    output logic                      busy
);
    localparam int BW_OFFSET    = calc_bw_offset(BW_ROW_BUFFER);
    localparam int NUM_BEAT_MAX = calc_num_beat(BW_ROW_BUFFER, BW_AXI_DATA);
    localparam int BW_STRB      = calc_bw_strb(BW_AXI_DATA);
    localparam int NUM_BYTE_ROW = calc_bw_strb(BW_ROW_BUFFER);

    state_e                   state_q, state_d;
    logic [BW_ROW_BUFFER-1:0] shifted_q, shifted_d, shift_out_s;
    logic [NUM_BYTE_ROW-1:0]  mask_q, mask_d, mask_s;
    logic [7:0]               beat_q, beat_d;
    logic [7:0]               alen_q, alen_d;
    logic [BW_OFFSET-1:0]     eff_offset_s;
    logic [31:0]              first_s, end_s;
    logic                     hs_s, last_s, req_ready_s, accept_s;
    logic [BW_AXI_DATA-1:0]   wdata_s;
    logic [BW_STRB-1:0]       wstrb_s;

    assign first_s = 32'(eff_offset_s >> 3);

`ifdef DCA_LSU_WRITE_SUBBYTE_EN
    // A partial leading byte occupies one extra strobe lane
    assign eff_offset_s = bus.req_offset;
    assign end_s        = first_s + 32'(bus.req_num_byte)
                        + ((bus.req_offset[2:0] != 3'b000) ? 32'd1 : 32'd0);
`else
    assign eff_offset_s = {bus.req_offset[BW_OFFSET-1:3], 3'b000};
    assign end_s        = first_s + 32'(bus.req_num_byte);
`endif

    ERVP_BARREL_SHIFTER #(
        .BW_DATA          (BW_ROW_BUFFER),
        .BW_SHIFT_AMOUNT  (BW_OFFSET),
        .SIGNED_AMOUNT    (0),
        .PLUS_TO_LEFT     (1),
        .ARITHMETIC_SHIFT (0),
        .CIRCULAR_SHIFT   (0),
        .MSB_FILL_VALUE   (0)
    ) u_shifter (
        .data_input   (bus.req_data),
        .shift_amount (eff_offset_s),
        .data_output  (shift_out_s)
    );

    // Byte-strobe mask over the row; lanes past the row end simply never match
    always_comb begin
        mask_s = '0;
        for (int i = 0; i < NUM_BYTE_ROW; i++) begin
            mask_s[i] = (32'(i) >= first_s) && (32'(i) < end_s);
        end
    end

    // Beat slice selection; beats beyond the row carry no data and no strobes
    always_comb begin
        wdata_s = '0;
        wstrb_s = '0;
        if (state_q == ST_SEND) begin
            for (int i = 0; i < NUM_BEAT_MAX; i++) begin
                wdata_s = wdata_s | ((beat_q == 8'(i)) ? shifted_q[i*BW_AXI_DATA +: BW_AXI_DATA] : '0);
                wstrb_s = wstrb_s | ((beat_q == 8'(i)) ? mask_q[i*BW_STRB +: BW_STRB] : '0);
            end
        end else begin
            wdata_s = '0;
            wstrb_s = '0;
        end
    end

    assign hs_s        = (state_q == ST_SEND) && bus.wready;
    assign last_s      = (state_q == ST_SEND) && (beat_q == alen_q);
    assign req_ready_s = (state_q == ST_IDLE) || (hs_s && last_s);
    assign accept_s    = bus.req_valid && req_ready_s;

    // Next-state: accepting on the last handshake reloads without an idle bubble
    always_comb begin
        state_d   = state_q;
        shifted_d = shifted_q;
        mask_d    = mask_q;
        beat_d    = beat_q;
        alen_d    = alen_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_SEND;
                    shifted_d = shift_out_s;
                    mask_d    = mask_s;
                    beat_d    = 8'd0;
                    alen_d    = bus.req_alen;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (hs_s && last_s) begin
                    if (accept_s) begin
                        state_d   = ST_SEND;
                        shifted_d = shift_out_s;
                        mask_d    = mask_s;
                        beat_d    = 8'd0;
                        alen_d    = bus.req_alen;
                    end else begin
                        state_d = ST_IDLE;
                        beat_d  = 8'd0;
                    end
                end else if (hs_s) begin
                    beat_d = beat_q + 8'd1;
                end else begin
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = 8'd0;
            end
        endcase
    end

    // State and burst registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shifted_q <= '0;
            mask_q    <= '0;
            beat_q    <= 8'd0;
            alen_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            shifted_q <= shifted_d;
            mask_q    <= mask_d;
            beat_q    <= beat_d;
            alen_q    <= alen_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.wvalid    = (state_q == ST_SEND);
    assign bus.wdata     = wdata_s;
    assign bus.wstrb     = wstrb_s;
    assign bus.wlast     = last_s;
    assign busy          = (state_q == ST_SEND);

endmodule

// File: tb/tb_dca_lsu_write_aligner.sv
// Directed self-checking bench for dca_lsu_write_aligner (32-bit W data, 128-bit row).
module tb_dca_lsu_write_aligner;
    localparam int BW_AXI_DATA   = 32;
    localparam int BW_ROW_BUFFER = 128;
    localparam int BW_NUM_BYTE   = 5;
    localparam logic [127:0] ROW = 128'hFEDCBA98_76543210_0123ABCD_89ABCDEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_checks = 0;
    int   n_errors = 0;

    dca_lsu_write_aligner_if #(
        .BW_AXI_DATA(BW_AXI_DATA), .BW_ROW_BUFFER(BW_ROW_BUFFER), .BW_NUM_BYTE(BW_NUM_BYTE)
    ) bus_if ();

    dca_lsu_write_aligner #(
        .BW_AXI_DATA(BW_AXI_DATA), .BW_ROW_BUFFER(BW_ROW_BUFFER), .BW_NUM_BYTE(BW_NUM_BYTE)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [127:0] data, input logic [6:0] off,
                             input logic [4:0] nb, input logic [7:0] alen);
        bus_if.req_data     = data;
        bus_if.req_offset   = off;
        bus_if.req_num_byte = nb;
        bus_if.req_alen     = alen;
        bus_if.req_valid    = 1'b1;
    endtask

    task automatic check_beat(input string tag, input logic [31:0] d, input logic [3:0] s, input logic l);
        check_val({tag, ".wvalid"}, bus_if.wvalid, 1'b1);
        check_val({tag, ".wdata"},  bus_if.wdata,  d);
        check_val({tag, ".wstrb"},  bus_if.wstrb,  s);
        check_val({tag, ".wlast"},  bus_if.wlast,  l);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, ".wvalid"},    bus_if.wvalid,    1'b0);
        check_val({tag, ".wlast"},     bus_if.wlast,     1'b0);
        check_val({tag, ".wdata"},     bus_if.wdata,     32'h0);
        check_val({tag, ".wstrb"},     bus_if.wstrb,     4'h0);
        check_val({tag, ".busy"},      busy,             1'b0);
        check_val({tag, ".req_ready"}, bus_if.req_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] row_d [6];
        row_d = '{32'h89ABCDEF, 32'h0123ABCD, 32'h76543210, 32'hFEDCBA98, 32'h0, 32'h0};

        bus_if.req_valid    = 1'b0;
        bus_if.req_data     = '0;
        bus_if.req_offset   = '0;
        bus_if.req_num_byte = '0;
        bus_if.req_alen     = 8'd0;
        bus_if.wready       = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check_idle("reset");

        // Aligned full row, 4 beats
        drive_req(ROW, 7'd0, 5'd16, 8'd3);
        #1 check_val("t1.accept", bus_if.req_ready, 1'b1);
        tick();
        bus_if.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("t1.b%0d", i), row_d[i], 4'hF, (i == 3));
            if (i == 3) check_val("t1.ready_last", bus_if.req_ready, 1'b1);
            tick();
        end
        check_idle("t1.end");

        // Byte offset of one
        drive_req(128'hDDCCBBAA, 7'd8, 5'd4, 8'd1);
        tick();
        bus_if.req_valid = 1'b0;
        check_beat("t2.b0", 32'hCCBBAA00, 4'hE, 1'b0);
        tick();
        check_beat("t2.b1", 32'h000000DD, 4'h1, 1'b1);
        tick();
        check_idle("t2.end");

        // Backpressure on beat 1
        drive_req(ROW, 7'd0, 5'd16, 8'd3);
        tick();
        bus_if.req_valid = 1'b0;
        check_beat("t3.b0", row_d[0], 4'hF, 1'b0);
        tick();
        bus_if.wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat($sformatf("t3.stall%0d", i), row_d[1], 4'hF, 1'b0);
            check_val($sformatf("t3.stall%0d.ready", i), bus_if.req_ready, 1'b0);
            tick();
        end
        bus_if.wready = 1'b1;
        check_beat("t3.b1", row_d[1], 4'hF, 1'b0);
        tick();
        check_beat("t3.b2", row_d[2], 4'hF, 1'b0);
        tick();
        check_beat("t3.b3", row_d[3], 4'hF, 1'b1);
        tick();
        check_idle("t3.end");

        // Back-to-back requests with no bubble
        drive_req(128'hDDCCBBAA, 7'd8, 5'd4, 8'd1);
        tick();
        bus_if.req_valid = 1'b0;
        check_beat("t4.a0", 32'hCCBBAA00, 4'hE, 1'b0);
        tick();
        check_beat("t4.a1", 32'h000000DD, 4'h1, 1'b1);
        drive_req(128'h11223344, 7'd0, 5'd4, 8'd0);
        #1 check_val("t4.accept", bus_if.req_ready, 1'b1);
        tick();
        bus_if.req_valid = 1'b0;
        check_val("t4.busy", busy, 1'b1);
        check_beat("t4.b0", 32'h11223344, 4'hF, 1'b1);
        tick();
        check_idle("t4.end");

        // Sub-byte offset
        drive_req(128'hAB, 7'd4, 5'd1, 8'd0);
        tick();
        bus_if.req_valid = 1'b0;
`ifdef DCA_LSU_WRITE_SUBBYTE_EN
        check_beat("t5.b0", 32'h00000AB0, 4'h3, 1'b1);
`else
        check_beat("t5.b0", 32'h000000AB, 4'h1, 1'b1);
`endif
        tick();
        check_idle("t5.end");

        // Burst longer than the row
        drive_req(ROW, 7'd0, 5'd16, 8'd5);
        tick();
        bus_if.req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_beat($sformatf("t6.b%0d", i), row_d[i], (i < 4) ? 4'hF : 4'h0, (i == 5));
            tick();
        end
        check_idle("t6.end");

        // Offset at the last byte: bytes past the row are dropped
        drive_req(ROW, 7'd120, 5'd4, 8'd3);
        tick();
        bus_if.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_beat($sformatf("t7.b%0d", i), (i == 3) ? 32'hEF000000 : 32'h0,
                       (i == 3) ? 4'h8 : 4'h0, (i == 3));
            tick();
        end
        check_idle("t7.end");

        // Zero bytes still emits the full burst
        drive_req(ROW, 7'd0, 5'd0, 8'd1);
        tick();
        bus_if.req_valid = 1'b0;
        check_beat("t8.b0", row_d[0], 4'h0, 1'b0);
        tick();
        check_beat("t8.b1", row_d[1], 4'h0, 1'b1);
        tick();
        check_idle("t8.end");

        // Reset abandons a burst mid-flight
        drive_req(ROW, 7'd0, 5'd16, 8'd3);
        tick();
        bus_if.req_valid = 1'b0;
        check_beat("t9.b0", row_d[0], 4'hF, 1'b0);
        tick();
        check_beat("t9.b1", row_d[1], 4'hF, 1'b0);
        tick();
        check_beat("t9.b2", row_d[2], 4'hF, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("t9.rst");
        tick();
        check_idle("t9.after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
